// File: rtl/dram_arbiter.sv
// Arbitrates one shared RAM/bus port between instruction fetch (ibus) and MEM-stage data (dbus),
// tracking in-flight reads in an in-order tag queue and steering responses back to their source.
module dram_arbiter #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned MAX_DSTREAK     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ibus_req,
    input  logic [XLEN-1:0]   ibus_addr,
    output logic              ibus_ready,
    input  logic              ibus_flush,
    output logic              ibus_rvalid,
    output logic [XLEN-1:0]   ibus_rdata,
    input  logic              dbus_req,
    input  logic              dbus_write,
    input  logic [XLEN-1:0]   dbus_addr,
    input  logic [XLEN-1:0]   dbus_wdata,
    input  logic [XLEN/8-1:0] dbus_strb,
    output logic              dbus_ready,
    output logic              dbus_rvalid,
    output logic [XLEN-1:0]   dbus_rdata,
    output logic              bus_req,
    output logic              bus_write,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [XLEN/8-1:0] bus_strb,
    input  logic              bus_ready,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic              err_unexpected_rsp
);

    localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);

    logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q, count_d;
    logic [SW-1:0]              streak_q, streak_d;
    logic [MAX_OUTSTANDING-1:0] src_q, src_d, drop_q, drop_d;
    logic                       err_q, err_d;

    logic full, q_empty, ibus_elig, dbus_elig, force_i, grant_i, grant_d;
    logic ibus_acc, dbus_acc, push, pop, head_src, head_drop;

    // Grant selection: dbus preferred, ibus forced through once the dbus streak saturates
    assign full      = (count_q == CW'(MAX_OUTSTANDING));
    assign q_empty   = (count_q == '0);
    assign ibus_elig = ibus_req & ~full;
    assign dbus_elig = dbus_req & (dbus_write | ~full);
    assign force_i   = (streak_q == SW'(MAX_DSTREAK));
    assign grant_i   = ibus_elig & (~dbus_elig | force_i);
    assign grant_d   = dbus_elig & ~grant_i;

    assign bus_req   = ibus_elig | dbus_elig;
    assign bus_write = grant_d & dbus_write;
    assign bus_addr  = grant_d ? dbus_addr  : ibus_addr;
    assign bus_wdata = grant_d ? dbus_wdata : '0;
    assign bus_strb  = grant_d ? dbus_strb  : '1;

    assign ibus_ready = grant_i & bus_ready;
    assign dbus_ready = grant_d & bus_ready;
    assign ibus_acc   = ibus_ready;
    assign dbus_acc   = dbus_ready;
    assign push       = ibus_acc | (dbus_acc & ~dbus_write);
    assign pop        = bus_rvalid & ~q_empty;

    // Response routing straight from the queue head; a flush in the pop cycle also kills the fetch
    assign head_src    = src_q[rd_ptr_q];
    assign head_drop   = drop_q[rd_ptr_q];
    assign dbus_rvalid = pop & head_src;
    assign ibus_rvalid = pop & ~head_src & ~head_drop & ~ibus_flush;
    assign ibus_rdata  = bus_rdata;
    assign dbus_rdata  = bus_rdata;

    assign err_unexpected_rsp = err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        streak_d = streak_q;
        src_d    = src_q;
        drop_d   = drop_q;
        err_d    = err_q | (bus_rvalid & q_empty);

        // Flush marks fetch entries first so a fetch pushed this cycle stays live
        if (ibus_flush) begin
            drop_d = drop_q | ~src_q;
        end
        if (push) begin
            src_d[wr_ptr_q]  = grant_d;
            drop_d[wr_ptr_q] = 1'b0;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        if (!ibus_req || ibus_acc) begin
            streak_d = '0;
        end else if (dbus_acc && !force_i) begin
            streak_d = streak_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            streak_q <= '0;
            src_q    <= '0;
            drop_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            streak_q <= streak_d;
            src_q    <= src_d;
            drop_q   <= drop_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios with literal expectations, then random traffic
// compared every cycle against a queue-based model of the arbiter.
module tb_dram_arbiter;

    localparam int unsigned XLEN = 32;
    localparam int unsigned MAXO = 4;
    localparam int unsigned MAXD = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              ibus_req, ibus_flush, ibus_ready, ibus_rvalid;
    logic [XLEN-1:0]   ibus_addr, ibus_rdata;
    logic              dbus_req, dbus_write, dbus_ready, dbus_rvalid;
    logic [XLEN-1:0]   dbus_addr, dbus_wdata, dbus_rdata;
    logic [XLEN/8-1:0] dbus_strb, bus_strb;
    logic              bus_req, bus_write, bus_ready, bus_rvalid, err_unexpected_rsp;
    logic [XLEN-1:0]   bus_addr, bus_wdata, bus_rdata;

    dram_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(MAXO), .MAX_DSTREAK(MAXD)) dut (
        .clk(clk), .rst(rst),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr), .ibus_ready(ibus_ready),
        .ibus_flush(ibus_flush), .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
        .dbus_req(dbus_req), .dbus_write(dbus_write), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_strb(dbus_strb), .dbus_ready(dbus_ready),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_strb(bus_strb), .bus_ready(bus_ready),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .err_unexpected_rsp(err_unexpected_rsp)
    );

    always #5 clk = ~clk;

    typedef struct {bit src; bit drop;} ent_t;
    ent_t mq[$];
    int   mstreak;
    bit   merr;
    bit   m_ia, m_da, m_pop;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Settle inputs, derive the required outputs from the model and compare
    task automatic settle();
        bit full, ie, de, gi, gd, eb;
        #1;
        full  = (mq.size() == MAXO);
        ie    = ibus_req && !full;
        de    = dbus_req && (dbus_write || !full);
        gi    = ie && (!de || mstreak == MAXD);
        gd    = de && !gi;
        eb    = ie || de;
        m_ia  = gi && bus_ready;
        m_da  = gd && bus_ready;
        m_pop = bus_rvalid && mq.size() > 0;
        chk("bus_req", bus_req, eb);
        chk("ibus_ready", ibus_ready, m_ia);
        chk("dbus_ready", dbus_ready, m_da);
        if (eb) begin
            chk("bus_write", bus_write, gd && dbus_write);
            chk("bus_addr", bus_addr, gd ? dbus_addr : ibus_addr);
            chk("bus_strb", bus_strb, gd ? dbus_strb : 4'hF);
            if (gd) chk("bus_wdata", bus_wdata, dbus_wdata);
        end
        chk("dbus_rvalid", dbus_rvalid, m_pop && mq[0].src);
        chk("ibus_rvalid", ibus_rvalid, m_pop && !mq[0].src && !mq[0].drop && !ibus_flush);
        chk("ibus_rdata", ibus_rdata, bus_rdata);
        chk("dbus_rdata", dbus_rdata, bus_rdata);
        chk("err", err_unexpected_rsp, merr);
    endtask

    // Advance the model at the clock edge, then move to the next drive point
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mstreak = 0;
            merr    = 1'b0;
        end else begin
            if (bus_rvalid && mq.size() == 0) merr = 1'b1;
            if (ibus_flush) foreach (mq[k]) if (!mq[k].src) mq[k].drop = 1'b1;
            if (m_pop) void'(mq.pop_front());
            if (m_ia) mq.push_back('{src: 1'b0, drop: 1'b0});
            if (m_da && !dbus_write) mq.push_back('{src: 1'b1, drop: 1'b0});
            if (!ibus_req || m_ia) mstreak = 0;
            else if (m_da && mstreak < MAXD) mstreak++;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; ibus_req = 1'b0; ibus_flush = 1'b0; ibus_addr = '0;
        dbus_req = 1'b0; dbus_write = 1'b0; dbus_addr = '0; dbus_wdata = '0; dbus_strb = '0;
        bus_ready = 1'b1; bus_rvalid = 1'b0; bus_rdata = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        settle();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int k = 0; k < 20 && mq.size() > 0; k++) begin
            bus_rvalid = 1'b1;
            bus_rdata  = $urandom;
            settle();
            tick();
        end
        bus_rvalid = 1'b0;
        chk("drain_empty", mq.size(), 0);
    endtask

    initial begin
        string pat;
        logic [1:0] rv_exp [4];
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete(); mstreak = 0; merr = 1'b0;

        // Reset state
        settle();
        chk("rst_bus_req", bus_req, 0);
        chk("rst_err", err_unexpected_rsp, 0);
        tick();

        // Same-cycle load and fetch: dbus first, ibus next
        dbus_req = 1'b1; dbus_addr = 32'h100; ibus_req = 1'b1; ibus_addr = 32'h200;
        settle();
        chk("t1_first_addr", bus_addr, 32'h100);
        chk("t1_first_dready", dbus_ready, 1);
        tick();
        dbus_req = 1'b0;
        settle();
        chk("t1_second_addr", bus_addr, 32'h200);
        chk("t1_second_iready", ibus_ready, 1);
        tick();
        ibus_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hAAAA_0001;
        settle();
        chk("t1_rsp0_route", {ibus_rvalid, dbus_rvalid}, 2'b01);
        chk("t1_rsp0_data", dbus_rdata, 32'hAAAA_0001);
        tick();
        bus_rdata = 32'hBBBB_0002;
        settle();
        chk("t1_rsp1_route", {ibus_rvalid, dbus_rvalid}, 2'b10);
        chk("t1_rsp1_data", ibus_rdata, 32'hBBBB_0002);
        tick();
        idle();
        settle();
        tick();

        // Continuous contention: D,D,D,D,I repeating
        pat = "DDDDIDDDDI";
        for (int k = 0; k < 10; k++) begin
            ibus_req = 1'b1; ibus_addr = 32'h300 + 32'(k * 4);
            dbus_req = 1'b1; dbus_write = 1'b1; dbus_addr = 32'h500; dbus_wdata = 32'(k); dbus_strb = 4'h3;
            bus_rvalid = (mq.size() > 0);
            settle();
            chk("grant_pattern", {ibus_ready, dbus_ready}, (pat[k] == "I") ? 2'b10 : 2'b01);
            tick();
        end
        drain();

        // Queue full: loads stall, stores still pass, one response unblocks next cycle
        do_reset();
        for (int k = 0; k < 4; k++) begin
            dbus_req = 1'b1; dbus_write = 1'b0; dbus_addr = 32'h1000 + 32'(k * 4);
            settle();
            tick();
        end
        dbus_addr = 32'h2000;
        settle();
        chk("full_load_stall", dbus_ready, 0);
        chk("full_no_bus_req", bus_req, 0);
        tick();
        dbus_write = 1'b1; dbus_addr = 32'h40; dbus_wdata = 32'hCAFE_F00D; dbus_strb = 4'hF;
        settle();
        chk("full_store_ok", dbus_ready, 1);
        chk("full_store_addr", bus_addr, 32'h40);
        tick();
        dbus_write = 1'b0; dbus_addr = 32'h2000; bus_rvalid = 1'b1; bus_rdata = 32'h11;
        settle();
        chk("full_same_cycle_pop", {dbus_ready, dbus_rvalid}, 2'b01);
        tick();
        bus_rvalid = 1'b0;
        settle();
        chk("full_unblocked", dbus_ready, 1);
        tick();
        drain();

        // Flush: I0, D0, I1, then flush with new fetch I2
        do_reset();
        ibus_req = 1'b1; ibus_addr = 32'h10;
        settle(); tick();
        ibus_req = 1'b0; dbus_req = 1'b1; dbus_write = 1'b0; dbus_addr = 32'h20;
        settle(); tick();
        dbus_req = 1'b0; ibus_req = 1'b1; ibus_addr = 32'h14;
        settle(); tick();
        ibus_addr = 32'h800; ibus_flush = 1'b1;
        settle();
        chk("flush_new_fetch", ibus_ready, 1);
        tick();
        idle();
        rv_exp = '{2'b00, 2'b01, 2'b00, 2'b10};
        for (int k = 0; k < 4; k++) begin
            bus_rvalid = 1'b1; bus_rdata = 32'h900 + 32'(k);
            settle();
            chk("flush_route", {ibus_rvalid, dbus_rvalid}, rv_exp[k]);
            tick();
        end
        idle();

        // Unexpected response on an empty queue is sticky until reset
        do_reset();
        bus_rvalid = 1'b1;
        settle();
        chk("unexp_no_rvalid", {ibus_rvalid, dbus_rvalid}, 2'b00);
        tick();
        bus_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("unexp_sticky", err_unexpected_rsp, 1);
            tick();
        end
        do_reset();
        settle();
        chk("unexp_cleared", err_unexpected_rsp, 0);
        tick();

        // Reset with reads in flight: late responses become unexpected
        for (int k = 0; k < 2; k++) begin
            dbus_req = 1'b1; dbus_write = 1'b0; dbus_addr = 32'h3000 + 32'(k * 4);
            settle(); tick();
        end
        do_reset();
        bus_rvalid = 1'b1; bus_rdata = 32'h77;
        settle();
        chk("late_no_rvalid", {ibus_rvalid, dbus_rvalid}, 2'b00);
        tick();
        bus_rvalid = 1'b0;
        settle();
        chk("late_err", err_unexpected_rsp, 1);
        tick();

        // Random traffic against the model; requesters hold until accepted
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (!(ibus_req && !m_ia)) begin
                ibus_req  = ($urandom_range(0, 2) != 0);
                ibus_addr = $urandom;
            end
            if (!(dbus_req && !m_da)) begin
                dbus_req   = ($urandom_range(0, 2) != 0);
                dbus_write = $urandom_range(0, 1) == 1;
                dbus_addr  = $urandom;
                dbus_wdata = $urandom;
                dbus_strb  = 4'($urandom);
            end
            ibus_flush = ($urandom_range(0, 19) == 0);
            bus_ready  = ($urandom_range(0, 3) != 0);
            bus_rvalid = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
            bus_rdata  = $urandom;
            settle();
            tick();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
